// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory read-port arbiter.
// Also holds the misalignment helper used on the captured address.
package imem_pkg;

    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 4;

    // The word index is addr[WIDX_HI:WIDX_LO].
    // The bits below WIDX_LO are the byte offset inside a word.
    localparam int WIDX_HI = 16;
    localparam int WIDX_LO = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LD   = 2'd2
    } gnt_e;

    function automatic logic misaligned(input logic [WIDX_LO-1:0] offs);
        return offs != '0;
    endfunction

endpackage

// File: rtl/imem_rsp_slot.sv
// One-entry response register with a valid/ready handshake.
// It supports capture, an optional flush, and an error flag.
module imem_rsp_slot #(
    parameter int DATA_W = imem_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] capture_data,
    input  logic              capture_err,
    input  logic              flush,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              free
);

    // The slot counts as free when it is already being drained this cycle.
    // This lets a new capture follow a consume with no gap.
    assign free = !rsp_valid || rsp_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= capture_data;
            rsp_err   <= capture_err;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one combinational instruction-memory read port between fetch (IF) and the load unit (LD).
// IF has fixed priority, and a starvation limit guarantees LD progress.
module imem_arbiter #(
    parameter int ADDR_W     = imem_pkg::ADDR_W,
    parameter int DATA_W     = imem_pkg::DATA_W,
    parameter int STARVE_MAX = imem_pkg::STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_rsp_valid,
    input  logic              ld_rsp_ready,
    output logic [DATA_W-1:0] ld_rsp_data,
    output logic              ld_rsp_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    import imem_pkg::*;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    gnt_e              gnt;
    logic              if_free;
    logic              ld_free;
    logic              if_elig;
    logic              ld_elig;
    logic              cap_err;
    logic [DATA_W-1:0] cap_data;
    logic [CNT_W-1:0]  starve_cnt;

    // Gating on reset_n keeps both ready outputs low during reset.
    assign if_elig = reset_n && if_req_valid && if_free && !if_flush;
    assign ld_elig = reset_n && ld_req_valid && ld_free;

    always_comb begin
        gnt = GNT_NONE;
        if (ld_elig && (!if_elig || starve_cnt == STARVE_LIM)) begin
            gnt = GNT_LD;
        end else if (if_elig) begin
            gnt = GNT_IF;
        end
    end

    assign if_req_ready = (gnt == GNT_IF);
    assign ld_req_ready = (gnt == GNT_LD);

    // The address defaults to if_addr so the memory port is always driven.
    assign rom_addr = (gnt == GNT_LD) ? ld_addr : if_addr;

    // Only one grant exists per cycle, so both slots share the captured word.
    assign cap_err  = misaligned(rom_addr[WIDX_LO-1:0]);
    assign cap_data = cap_err ? '0 : rom_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (gnt == GNT_LD || !ld_req_valid) begin
            starve_cnt <= '0;
        end else if (gnt == GNT_IF && starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    imem_rsp_slot #(.DATA_W(DATA_W)) u_if_slot (
        .clock        (clock),
        .reset_n      (reset_n),
        .capture      (gnt == GNT_IF),
        .capture_data (cap_data),
        .capture_err  (cap_err),
        .flush        (if_flush),
        .rsp_ready    (if_rsp_ready),
        .rsp_valid    (if_rsp_valid),
        .rsp_data     (if_rsp_data),
        .rsp_err      (if_rsp_err),
        .free         (if_free)
    );

    imem_rsp_slot #(.DATA_W(DATA_W)) u_ld_slot (
        .clock        (clock),
        .reset_n      (reset_n),
        .capture      (gnt == GNT_LD),
        .capture_data (cap_data),
        .capture_err  (cap_err),
        .flush        (1'b0),
        .rsp_ready    (ld_rsp_ready),
        .rsp_valid    (ld_rsp_valid),
        .rsp_data     (ld_rsp_data),
        .rsp_err      (ld_rsp_err),
        .free         (ld_free)
    );

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared against a behavioural model.
module tb_imem_arbiter;

    localparam int SMAX = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req_valid, if_req_ready, if_flush;
    logic [16:0] if_addr;
    logic        if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_rsp_data;
    logic        ld_req_valid, ld_req_ready;
    logic [16:0] ld_addr;
    logic        ld_rsp_valid, ld_rsp_ready, ld_rsp_err;
    logic [31:0] ld_rsp_data;
    logic [16:0] rom_addr;
    logic [31:0] rom_data;

    logic [31:0] mem [0:32767];

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state.
    bit          mIfValid, mIfErr, mLdValid, mLdErr;
    logic [31:0] mIfData, mLdData;
    int          mStarve;
    bit          expIfGnt, expLdGnt;
    bit          gotIfRdy, gotLdRdy;

    always #5 clock = ~clock;

    assign rom_data = mem[rom_addr[16:2]];

    imem_arbiter #(.ADDR_W(17), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_addr      (ld_addr),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_ready (ld_rsp_ready),
        .ld_rsp_data  (ld_rsp_data),
        .ld_rsp_err   (ld_rsp_err),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data)
    );

    function automatic logic [31:0] memRead(input logic [16:0] a);
        if (a % 4 != 0) return 32'h0;
        return mem[a / 4];
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mIfValid = 0; mIfErr = 0; mIfData = '0;
        mLdValid = 0; mLdErr = 0; mLdData = '0;
        mStarve  = 0;
    endtask

    task automatic applyStimulus(input bit rst, input bit ifv, input logic [16:0] ifa, input bit fl,
                                 input bit ifrr, input bit ldv, input logic [16:0] lda, input bit ldrr);
        reset_n      = !rst;
        if_req_valid = ifv;
        if_addr      = ifa;
        if_flush     = fl;
        if_rsp_ready = ifrr;
        ld_req_valid = ldv;
        ld_addr      = lda;
        ld_rsp_ready = ldrr;
        if (rst) modelReset();
    endtask

    // Work out the grant from the arbitration rules, then compare all outputs.
    task automatic checkOutput();
        bit ifE, ldE;
        ifE = if_req_valid && (!mIfValid || if_rsp_ready) && !if_flush;
        ldE = ld_req_valid && (!mLdValid || ld_rsp_ready);
        if (!reset_n) begin
            expLdGnt = 0;
            expIfGnt = 0;
        end else begin
            expLdGnt = ldE && (!ifE || mStarve == SMAX);
            expIfGnt = ifE && !expLdGnt;
        end
        gotIfRdy = if_req_ready;
        gotLdRdy = ld_req_ready;
        checkVal("if_req_ready", 32'(if_req_ready), 32'(expIfGnt));
        checkVal("ld_req_ready", 32'(ld_req_ready), 32'(expLdGnt));
        checkVal("rom_addr", 32'(rom_addr), 32'(expLdGnt ? ld_addr : if_addr));
        checkVal("if_rsp_valid", 32'(if_rsp_valid), 32'(mIfValid));
        checkVal("ld_rsp_valid", 32'(ld_rsp_valid), 32'(mLdValid));
        if (mIfValid) begin
            checkVal("if_rsp_data", if_rsp_data, mIfData);
            checkVal("if_rsp_err", 32'(if_rsp_err), 32'(mIfErr));
        end
        if (mLdValid) begin
            checkVal("ld_rsp_data", ld_rsp_data, mLdData);
            checkVal("ld_rsp_err", 32'(ld_rsp_err), 32'(mLdErr));
        end
    endtask

    task automatic updateModel();
        if (!reset_n) return;
        if (expIfGnt) begin
            mIfValid = 1; mIfData = memRead(if_addr); mIfErr = (if_addr % 4 != 0);
        end else if (if_flush || if_rsp_ready) begin
            mIfValid = 0;
        end
        if (expLdGnt) begin
            mLdValid = 1; mLdData = memRead(ld_addr); mLdErr = (ld_addr % 4 != 0);
        end else if (ld_rsp_ready) begin
            mLdValid = 0;
        end
        if (expLdGnt || !ld_req_valid) mStarve = 0;
        else if (expIfGnt && mStarve < SMAX) mStarve = mStarve + 1;
    endtask

    task automatic runCycle(input bit rst, input bit ifv, input logic [16:0] ifa, input bit fl,
                            input bit ifrr, input bit ldv, input logic [16:0] lda, input bit ldrr);
        @(negedge clock);
        applyStimulus(rst, ifv, ifa, fl, ifrr, ldv, lda, ldrr);
        #1;
        checkOutput();
        @(posedge clock);
        updateModel();
        #1;
    endtask

    int pattern [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = $urandom;
        mem[2] = 32'h00200113;
        modelReset();
        applyStimulus(1, 1, 17'h10, 0, 1, 1, 17'h20, 1);

        // Reset with both requests valid.
        for (int i = 0; i < 3; i++) runCycle(1, 1, 17'h10, 0, 1, 1, 17'h20, 1);
        checkVal("rst_if_ready", 32'(gotIfRdy), 32'h0);
        checkVal("rst_ld_ready", 32'(gotLdRdy), 32'h0);
        checkVal("rst_if_valid", 32'(if_rsp_valid), 32'h0);
        checkVal("rst_if_data", if_rsp_data, 32'h0);
        checkVal("rst_ld_data", ld_rsp_data, 32'h0);
        checkVal("rst_rom_addr", 32'(rom_addr), 32'h10);
        runCycle(0, 1, 17'h10, 0, 1, 1, 17'h20, 1);
        checkVal("post_rst_if_first", 32'(gotIfRdy), 32'h1);
        checkVal("post_rst_ld_first", 32'(gotLdRdy), 32'h0);

        // IF only: one-cycle latency, then back-to-back fetches.
        runCycle(0, 1, 17'h8, 0, 1, 0, 17'h0, 1);
        checkVal("if_only_ready", 32'(gotIfRdy), 32'h1);
        checkVal("if_only_valid", 32'(if_rsp_valid), 32'h1);
        checkVal("if_only_data", if_rsp_data, 32'h00200113);
        for (int i = 0; i < 4; i++) begin
            runCycle(0, 1, 17'(12 + 4 * i), 0, 1, 0, 17'h0, 1);
            checkVal("if_b2b_ready", 32'(gotIfRdy), 32'h1);
            checkVal("if_b2b_data", if_rsp_data, mem[3 + i]);
        end

        // Contention: the LD request waits behind STARVE_MAX IF grants.
        for (int i = 0; i < 10; i++) begin
            runCycle(0, 1, 17'(17'h100 + 4 * i), 0, 1, 1, 17'h40, 1);
            checkVal("contention_grant", gotLdRdy ? 32'h2 : (gotIfRdy ? 32'h1 : 32'h0), 32'(pattern[i]));
            if (i == 4) checkVal("contention_ld_data", ld_rsp_data, mem[16]);
        end

        // Backpressure on the LD slot.
        runCycle(0, 0, 17'h0, 0, 1, 0, 17'h0, 1);
        runCycle(0, 0, 17'h0, 0, 1, 1, 17'h24, 0);
        for (int i = 0; i < 5; i++) begin
            runCycle(0, 0, 17'h0, 0, 1, 1, 17'h28, 0);
            checkVal("bp_ld_ready", 32'(gotLdRdy), 32'h0);
            checkVal("bp_ld_data", ld_rsp_data, mem[9]);
        end
        runCycle(0, 0, 17'h0, 0, 1, 1, 17'h28, 1);
        checkVal("bp_passthru_ready", 32'(gotLdRdy), 32'h1);
        checkVal("bp_passthru_data", ld_rsp_data, mem[10]);
        runCycle(0, 0, 17'h0, 0, 1, 0, 17'h0, 1);
        checkVal("bp_drain_valid", 32'(ld_rsp_valid), 32'h0);

        // Misaligned LD access.
        runCycle(0, 0, 17'h0, 0, 1, 1, 17'h6, 1);
        checkVal("mis_err", 32'(ld_rsp_err), 32'h1);
        checkVal("mis_data", ld_rsp_data, 32'h0);

        // Flush while the IF response is held.
        runCycle(0, 1, 17'h8, 0, 0, 0, 17'h0, 1);
        runCycle(0, 1, 17'hC, 1, 0, 1, 17'h30, 1);
        checkVal("flush_if_ready", 32'(gotIfRdy), 32'h0);
        checkVal("flush_ld_ready", 32'(gotLdRdy), 32'h1);
        checkVal("flush_if_valid", 32'(if_rsp_valid), 32'h0);
        checkVal("flush_ld_data", ld_rsp_data, mem[12]);

        // Randomized traffic, with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            logic [16:0] ia, la;
            ia = 17'($urandom_range(0, 131071));
            la = 17'($urandom_range(0, 131071));
            if ($urandom % 4 != 0) ia[1:0] = 2'b00;
            if ($urandom % 4 != 0) la[1:0] = 2'b00;
            runCycle($urandom_range(0, 399) == 0, $urandom % 4 != 0, ia, $urandom % 10 == 0,
                     $urandom % 10 < 7, $urandom % 2 == 0, la, $urandom % 10 < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational instruction-memory read port (17-bit byte address, word index = addr[16:2], 32-bit data) between two requesters: the instruction-fetch unit (IF) and the load unit reading constants from instruction memory (LD).
- Fetch has fixed priority, with a starvation limit for LD.
- Read data is captured into one response slot per requester, giving a fixed 1-cycle latency and a valid/ready response handshake.
- Sits between the fetch/LSU logic and the instruction memory.

Parameters:
- ADDR_W, 17, byte-address width of the instruction memory.
- DATA_W, 32, instruction/data word width.
- STARVE_MAX, 4, maximum consecutive IF grants while an LD request is waiting; range 1..15.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  ADDR_W  IF byte address.
- if_flush  in  1  discard IF response slot (branch/redirect).
- if_rsp_valid  out  1  IF response held.
- if_rsp_ready  in  1  IF consumes response.
- if_rsp_data  out  DATA_W  IF read word.
- if_rsp_err  out  1  IF address misaligned.
- ld_req_valid  in  1  LD read request.
- ld_req_ready  out  1  LD request accepted this cycle.
- ld_addr  in  ADDR_W  LD byte address.
- ld_rsp_valid  out  1  LD response held.
- ld_rsp_ready  in  1  LD consumes response.
- ld_rsp_data  out  DATA_W  LD read word.
- ld_rsp_err  out  1  LD address misaligned.
- rom_addr  out  ADDR_W  address to instruction memory.
- rom_data  in  DATA_W  combinational read data from instruction memory.

Behaviour:

Reset (reset_n low, asynchronous):
- All rsp_valid, rsp_err and rsp_data are 0; starvation counter is 0.
- req_ready outputs are 0 while reset_n is low.
- A reset mid-transaction drops both slots silently.

Slot free:
- A requester's slot is free when its rsp_valid=0, or rsp_valid&rsp_ready in the same cycle (pass-through allowed).

Eligibility:
- IF is eligible when if_req_valid, its slot is free, and if_flush=0.
- LD is eligible when ld_req_valid and its slot is free.

Grant (combinational, at most one per cycle):
- LD is granted if LD is eligible and (IF is not eligible, or starve_cnt==STARVE_MAX).
- Otherwise IF is granted if IF is eligible.
- req_ready = grant for that requester.

rom_addr:
- Carries the granted requester's address.
- With no grant it carries if_addr, so rom_addr never floats.

Capture:
- On an accepted request, the clock edge loads the slot with rsp_data = rom_data and rsp_err = (addr[1:0]!=0).
- rsp_valid=1 from the next cycle: latency is exactly 1 cycle.
- If misaligned: rsp_data=0, rsp_err=1. The word index still uses addr[16:2]; it is not used for data.

Hold:
- A slot holds data, err and valid stable until rsp_ready. Then valid clears unless a new capture happens on the same edge.

Flush:
- if_flush=1 clears if_rsp_valid at the next edge regardless of if_rsp_ready.
- IF is not granted in a flush cycle, so no stale fetch is captured.
- LD is unaffected by flush.

Starvation counter (4 bits):
- Increments on an IF grant while ld_req_valid=1.
- Resets to 0 on an LD grant or when ld_req_valid=0.
- Saturates at STARVE_MAX.

Simultaneous events:
- IF and LD both eligible with counter < STARVE_MAX: IF wins.
- Response consume and new capture on the same edge: new data is loaded and valid stays 1.

Decomposition:
- Package imem_pkg holds ADDR_W, DATA_W, STARVE_MAX defaults, word-index slice constants (WIDX_HI=16, WIDX_LO=2) and the grant enum {GNT_NONE, GNT_IF, GNT_LD}.
- Sub-module imem_rsp_slot is a one-entry response register with valid/ready, capture, flush and err. It is instantiated twice; IF uses the flush input, LD ties it to 0.
- The arbiter and starvation counter live in the top module.

Test Plan:
1. Reset: hold reset_n=0 with both requests valid -> all rsp_valid=0, req_ready=0, rom_addr=if_addr. Release reset: first cycle grants IF.
2. IF only: if_addr=0x00008, memory word 2 = 0x00200113, if_rsp_ready=1 -> if_req_ready=1 in cycle N, if_rsp_valid=1 with data 0x00200113 in N+1. Back-to-back every cycle gives one response per cycle.
3. Contention: both requesting continuously, STARVE_MAX=4, all rsp_ready=1 -> grant pattern IF,IF,IF,IF,LD, repeating; the LD response carries the word at ld_addr.
4. Backpressure: ld_rsp_ready=0 after a capture -> ld_req_ready=0 and ld_rsp_data stable for 5 cycles. Assert ready -> valid drops at the next edge; a new request is accepted the same cycle ready=1.
5. Misaligned: ld_addr=0x00006 -> ld_rsp_err=1, ld_rsp_data=0 next cycle.
6. Flush: if_rsp_valid=1, if_rsp_ready=0, then if_flush=1 with if_req_valid=1 -> if_req_ready=0 that cycle and if_rsp_valid=0 next cycle. A concurrent LD request is granted in the flush cycle.
